// File: rtl/uart_fifo.sv
// uart_fifo: buffered UART with TX/RX FIFOs, parity, sticky errors and irq; ports clk/rst, rx/tx line, a/d/we/spo register bus, irq, rxnew/rxdata receive event
module uart_fifo_buf #(
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic [7:0]             din_i,
  output logic [7:0]             head_o,
  output logic [$clog2(DEPTH):0] cnt_o
);
  localparam int AW = $clog2(DEPTH);
  logic [7:0] mem_q [DEPTH];
  logic [AW-1:0] rd_q, wr_q;
  logic [AW:0] cnt_q;
  logic do_push, do_pop;
  assign do_pop = pop_i && cnt_q != '0;
  assign do_push = push_i && (cnt_q != (AW+1)'(DEPTH) || do_pop);
  assign head_o = mem_q[rd_q];
  assign cnt_o = cnt_q;
  always_ff @(posedge clk) if (do_push) mem_q[wr_q] <= din_i;
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_q <= '0;
      wr_q <= '0;
      cnt_q <= '0;
    end else begin
      rd_q <= rd_q + AW'(do_pop);
      wr_q <= wr_q + AW'(do_push);
      cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
endmodule

module uart_fifo #(
  parameter int CLOCK_FREQ = 62500000,
  parameter int BAUD_RATE  = 115200,
  parameter int OVERSAMPLE = 16,
  parameter int TX_DEPTH   = 16,
  parameter int RX_DEPTH   = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx,
  output logic        tx,
  input  logic [2:0]  a,
  input  logic [31:0] d,
  input  logic        we,
  output logic [31:0] spo,
  output logic        irq,
  output logic        rxnew,
  output logic [7:0]  rxdata
);
  localparam int DIV = (CLOCK_FREQ + BAUD_RATE * OVERSAMPLE / 2) / (BAUD_RATE * OVERSAMPLE);
  localparam int DW = $clog2(DIV) + 1;
  localparam int OW = $clog2(OVERSAMPLE);
  localparam int TW = $clog2(TX_DEPTH) + 1;
  localparam int RW = $clog2(RX_DEPTH) + 1;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  state_t txs_q, txs_d, rxs_q, rxs_d;
  logic [DW-1:0] bcnt_q;
  logic [OW-1:0] tos_q, tos_d, ros_q, ros_d;
  logic [2:0] tbit_q, tbit_d, rbit_q, rbit_d;
  logic [7:0] tsh_q, tsh_d, rsh_q, rsh_d, rxdata_q, tx_head, rx_head;
  logic [3:0] ctrl_q, flag_q;
  logic [TW-1:0] tx_cnt;
  logic [RW-1:0] rx_cnt;
  logic tpar_q, tpar_d, rpar_q, rpar_d, rs1_q, rs2_q, rxnew_q, rxnew_d;
  logic os_tick, tend, rend, rmid, frm_set, par_set, ovr_set;
  logic tx_push, tx_pop, rx_pop, tx_empty, tx_full, rx_ne, rx_full, unused_d;
  assign unused_d = ^d[23:0];
  assign os_tick = bcnt_q == DW'(DIV - 1);
  always_ff @(posedge clk) bcnt_q <= (rst || os_tick) ? '0 : bcnt_q + DW'(1);
  assign tx_push = we && a == 3'd0;
  assign rx_pop = we && a == 3'd1;
  assign tx_empty = tx_cnt == '0;
  assign tx_full = tx_cnt == TW'(TX_DEPTH);
  assign rx_ne = rx_cnt != '0;
  assign rx_full = rx_cnt == RW'(RX_DEPTH);
  uart_fifo_buf #(.DEPTH(TX_DEPTH)) u_txf (
    .clk, .rst, .push_i(tx_push), .pop_i(tx_pop), .din_i(d[31:24]), .head_o(tx_head), .cnt_o(tx_cnt)
  );
  uart_fifo_buf #(.DEPTH(RX_DEPTH)) u_rxf (
    .clk, .rst, .push_i(rxnew_q), .pop_i(rx_pop), .din_i(rxdata_q), .head_o(rx_head), .cnt_o(rx_cnt)
  );
  assign tend = os_tick && tos_q == OW'(OVERSAMPLE - 1);
  always_comb begin
    txs_d = txs_q;
    tos_d = tos_q;
    tbit_d = tbit_q;
    tsh_d = tsh_q;
    tpar_d = tpar_q;
    tx_pop = 1'b0;
    if (os_tick) tos_d = tend ? '0 : tos_q + OW'(1);
    case (txs_q)
      START: if (tend) begin
        txs_d = DATA;
        tbit_d = '0;
      end
      DATA: if (tend) begin
        tsh_d = tsh_q >> 1;
        tbit_d = tbit_q + 3'd1;
        if (tbit_q == 3'd7) txs_d = ctrl_q[1] ? PARITY : STOP;
      end
      PARITY: if (tend) txs_d = STOP;
      STOP: if (tend) txs_d = IDLE;
      default: ;
    endcase
    if (!tx_empty && (txs_q == IDLE || (txs_q == STOP && tend))) begin
      tx_pop = 1'b1;
      tsh_d = tx_head;
      tpar_d = ^tx_head ^ ctrl_q[0];
      tos_d = '0;
      txs_d = START;
    end
  end
  assign tx = txs_q == START ? 1'b0 : txs_q == DATA ? tsh_q[0] : txs_q == PARITY ? tpar_q : 1'b1;
  assign rend = os_tick && ros_q == OW'(OVERSAMPLE - 1);
  assign rmid = os_tick && ros_q == OW'(OVERSAMPLE / 2 - 1);
  always_comb begin
    rxs_d = rxs_q;
    ros_d = ros_q;
    rbit_d = rbit_q;
    rsh_d = rsh_q;
    rpar_d = rpar_q;
    rxnew_d = 1'b0;
    frm_set = 1'b0;
    par_set = 1'b0;
    ovr_set = 1'b0;
    if (os_tick) ros_d = rend ? '0 : ros_q + OW'(1);
    case (rxs_q)
      IDLE: if (os_tick && !rs2_q) begin
        rxs_d = START;
        ros_d = '0;
      end
      START: if (rmid) begin
        rxs_d = rs2_q ? IDLE : DATA;
        ros_d = '0;
        rbit_d = '0;
      end
      DATA: if (rend) begin
        rsh_d = {rs2_q, rsh_q[7:1]};
        rbit_d = rbit_q + 3'd1;
        if (rbit_q == 3'd7) rxs_d = ctrl_q[1] ? PARITY : STOP;
      end
      PARITY: if (rend) begin
        rpar_d = rs2_q;
        rxs_d = STOP;
      end
      STOP: if (rend) begin
        rxs_d = IDLE;
        frm_set = !rs2_q;
        par_set = rs2_q && ctrl_q[1] && rpar_q != (^rsh_q ^ ctrl_q[0]);
        ovr_set = rs2_q && !par_set && rx_full && !rx_pop;
        rxnew_d = rs2_q && !par_set && !ovr_set;
      end
      default: ;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      txs_q <= IDLE;
      rxs_q <= IDLE;
      tos_q <= '0;
      ros_q <= '0;
      tbit_q <= '0;
      rbit_q <= '0;
      tsh_q <= '0;
      rsh_q <= '0;
      tpar_q <= 1'b0;
      rpar_q <= 1'b0;
      rs1_q <= 1'b1;
      rs2_q <= 1'b1;
      rxnew_q <= 1'b0;
      rxdata_q <= '0;
      ctrl_q <= '0;
      flag_q <= '0;
    end else begin
      txs_q <= txs_d;
      rxs_q <= rxs_d;
      tos_q <= tos_d;
      ros_q <= ros_d;
      tbit_q <= tbit_d;
      rbit_q <= rbit_d;
      tsh_q <= tsh_d;
      rsh_q <= rsh_d;
      tpar_q <= tpar_d;
      rpar_q <= rpar_d;
      rs1_q <= rx;
      rs2_q <= rs1_q;
      rxnew_q <= rxnew_d;
      rxdata_q <= rxnew_d ? rsh_q : rxdata_q;
      ctrl_q <= (we && a == 3'd4) ? d[27:24] : ctrl_q;
      flag_q <= (flag_q & ~((we && a == 3'd3) ? d[31:28] : 4'd0))
              | {tx_push && tx_full && !tx_pop, par_set, frm_set, ovr_set};
    end
  end
  always_comb begin
    spo = '0;
    case (a)
      3'd0: spo[31:24] = rx_ne ? rx_head : 8'd0;
      3'd1: spo[24] = rx_ne;
      3'd2: spo[24] = tx_empty && txs_q == IDLE;
      3'd3: spo[31:24] = {flag_q, tx_full, tx_empty, rx_full, rx_ne};
      3'd4: spo[27:24] = ctrl_q;
      3'd5: spo[31:24] = 8'(rx_cnt);
      3'd6: spo[31:24] = 8'(tx_cnt);
      default: ;
    endcase
  end
  assign irq = (ctrl_q[2] & rx_ne) | (ctrl_q[3] & tx_empty);
  assign rxnew = rxnew_q;
  assign rxdata = rxdata_q;
endmodule

// File: tb/tb_uart_fifo.sv
// tb_uart_fifo: directed self-checking bench for uart_fifo
module tb_uart_fifo;
  localparam int BIT = 64;
  localparam int RXD = 4;
  logic clk = 1'b0, rst = 1'b1, rx_drv = 1'b1, loop = 1'b0, we = 1'b0;
  logic [2:0] a = 3'd0;
  logic [31:0] d = 32'd0;
  logic [31:0] spo;
  logic tx, irq, rxnew, rx;
  logic [7:0] rxdata;
  logic [19:0] bits;
  int tests = 0, fails = 0, n;
  assign rx = loop ? tx : rx_drv;
  uart_fifo #(.CLOCK_FREQ(6400), .BAUD_RATE(100), .OVERSAMPLE(16), .TX_DEPTH(4), .RX_DEPTH(RXD)) dut (
    .clk(clk), .rst(rst), .rx(rx), .tx(tx), .a(a), .d(d), .we(we),
    .spo(spo), .irq(irq), .rxnew(rxnew), .rxdata(rxdata)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask
  task automatic wr(input logic [2:0] addr, input logic [31:0] data);
    @(negedge clk);
    a = addr;
    d = data;
    we = 1'b1;
    @(negedge clk);
    we = 1'b0;
  endtask
  task automatic rd_check(input string tag, input logic [2:0] addr, input logic [31:0] exp);
    @(negedge clk);
    a = addr;
    #1 check(tag, spo, exp);
  endtask
  task automatic poll(input string tag, input logic [2:0] addr, input logic [31:0] exp, input int limit);
    int k = 0;
    @(negedge clk);
    a = addr;
    #1;
    while (spo !== exp && k < limit) begin
      @(negedge clk);
      #1;
      k++;
    end
    check(tag, spo, exp);
  endtask
  task automatic send_frame(input logic [7:0] b, input bit pe, input bit pb, input bit sb);
    rx_drv = 1'b0;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_drv = b[i];
      repeat (BIT) @(negedge clk);
    end
    if (pe) begin
      rx_drv = pb;
      repeat (BIT) @(negedge clk);
    end
    rx_drv = sb;
    repeat (BIT) @(negedge clk);
    rx_drv = 1'b1;
    repeat (BIT) @(negedge clk);
  endtask
  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_tx", tx, 1);
    check("rst_irq", irq, 0);
    check("rst_rxnew", rxnew, 0);
    check("rst_rxdata", rxdata, 0);
    rd_check("rst_a2", 3'd2, 32'h01000000);
    rd_check("rst_a3", 3'd3, 32'h04000000);
    rd_check("rst_a7", 3'd7, 32'h0);
    wr(3'd0, 32'h55000000);
    n = 0;
    while (tx !== 1'b0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("tx_first_edge", 32'(n <= 66 && tx === 1'b0), 1);
    wr(3'd0, 32'hA3000000);
    a = 3'd2;
    repeat (30) @(negedge clk);
    for (int k = 0; k < 20; k++) begin
      if (k > 0) repeat (BIT) @(negedge clk);
      bits[k] = tx;
      if (k == 5 || k == 19) check($sformatf("tx_busy%0d", k), spo, 32'h0);
    end
    check("tx_frame0", 32'(bits[9:0]), 32'({1'b1, 8'h55, 1'b0}));
    check("tx_frame1", 32'(bits[19:10]), 32'({1'b1, 8'hA3, 1'b0}));
    poll("tx_idle", 3'd2, 32'h01000000, 100);
    loop = 1'b1;
    wr(3'd4, 32'h03000000);
    wr(3'd0, 32'h00000000);
    wr(3'd0, 32'h01000000);
    wr(3'd0, 32'hFF000000);
    poll("lb_count", 3'd5, 32'h03000000, 3 * 11 * BIT + 300);
    poll("lb_txidle", 3'd2, 32'h01000000, 200);
    rd_check("lb_status", 3'd3, 32'h05000000);
    rd_check("lb_head0", 3'd0, 32'h00000000);
    wr(3'd1, 32'h0);
    rd_check("lb_head1", 3'd0, 32'h01000000);
    wr(3'd1, 32'h0);
    rd_check("lb_head2", 3'd0, 32'hFF000000);
    check("lb_rxdata", rxdata, 8'hFF);
    wr(3'd1, 32'h0);
    rd_check("lb_empty", 3'd1, 32'h0);
    loop = 1'b0;
    wr(3'd4, 32'h0);
    for (int i = 0; i < RXD + 1; i++) send_frame(8'(8'h11 * (i + 1)), 1'b0, 1'b0, 1'b1);
    rd_check("ovf_count", 3'd5, 32'h04000000);
    rd_check("ovf_status", 3'd3, 32'h17000000);
    check("ovf_rxdata", rxdata, 8'h44);
    for (int i = 0; i < RXD; i++) begin
      rd_check($sformatf("ovf_head%0d", i), 3'd0, {8'(8'h11 * (i + 1)), 24'h0});
      wr(3'd1, 32'h0);
    end
    wr(3'd3, 32'h10000000);
    rd_check("ovr_clear", 3'd3, 32'h04000000);
    send_frame(8'h5A, 1'b0, 1'b0, 1'b0);
    repeat (BIT) @(negedge clk);
    wr(3'd4, 32'h02000000);
    send_frame(8'h07, 1'b1, 1'b0, 1'b1);
    rd_check("err_status", 3'd3, 32'h64000000);
    rd_check("err_count", 3'd5, 32'h0);
    wr(3'd3, 32'h60000000);
    rd_check("err_clear", 3'd3, 32'h04000000);
    wr(3'd4, 32'h04000000);
    check("irq_idle", irq, 0);
    fork
      send_frame(8'hC3, 1'b0, 1'b0, 1'b1);
      begin
        n = 0;
        while (rxnew !== 1'b1 && n < 1500) begin
          @(negedge clk);
          n++;
        end
        check("irq_rxnew_seen", rxnew, 1);
        check("irq_before", irq, 0);
        check("irq_rxdata", rxdata, 8'hC3);
        @(negedge clk);
        check("irq_rise", irq, 1);
        check("rxnew_pulse", rxnew, 0);
      end
    join
    wr(3'd1, 32'h0);
    check("irq_fall", irq, 0);
    wr(3'd4, 32'h0);
    for (int i = 0; i < 6; i++) wr(3'd0, {8'(i + 1), 24'h0});
    rd_check("txf_count", 3'd6, 32'h04000000);
    rd_check("txf_status", 3'd3, 32'h88000000);
    n = 0;
    while (tx !== 1'b0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("rst_pre_tx", tx, 0);
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_tx", tx, 1);
    rst = 1'b0;
    rd_check("rst_mid_status", 3'd3, 32'h04000000);
    rd_check("rst_mid_txcnt", 3'd6, 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/uart_fifo.md
# uart_fifo

Buffered, parametrised UART peripheral for pComputer, the successor to the single-byte UART. It has independent TX and RX FIFOs, runtime-selectable parity and sticky error flags. A maskable level interrupt drives the interrupt controller. It sits on the pCPU I/O bus with the same word-addressed register interface; software that only uses offsets 0–2 keeps working apart from the new pop rule.

## Interface
- CLOCK_FREQ, 62500000: clk frequency in Hz.
- BAUD_RATE, 115200: line rate in baud.
- OVERSAMPLE, 16: RX samples per bit. Must be even and ≥ 8.
- TX_DEPTH, 16: TX FIFO entries. Power of two, 2–128.
- RX_DEPTH, 16: RX FIFO entries. Power of two, 2–128.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; synchronous, active-high.
- rx  in  1  serial input, asynchronous.
- tx  out  1  serial output; idles high.
- a  in  3  register word address.
- d  in  32  write data; byte fields live in d[31:24].
- we  in  1  write strobe, one cycle per access.
- spo  out  32  combinational read data for address a.
- irq  out  1  level interrupt.
- rxnew  out  1  one-cycle pulse when a byte is pushed into the RX FIFO.
- rxdata  out  8  the byte that was last pushed.

## Operation
Register map. All fields are in bits [31:24]; all other bits read 0.
- a=0, write: push d[31:24] into the TX FIFO. If the FIFO is full, the byte is dropped and tx_ovf is set.
- a=0, read: RX FIFO head byte, without popping. Reads 0 when the FIFO is empty.
- a=1, write: pop the RX FIFO. Ignored when empty.
- a=1, read: bit24 = RX not empty.
- a=2, read: bit24 = tx_idle, meaning the TX FIFO is empty and the shifter is idle.
- a=3, read status: bit24 rx_nonempty, bit25 rx_full, bit26 tx_empty, bit27 tx_full, bit28 rx_overrun, bit29 frame_err, bit30 parity_err, bit31 tx_ovf.
- a=3, write: write-1-to-clear for bits 28–31.
- a=4, read/write control: [25:24] parity (00 none, 01 none, 10 even, 11 odd), bit26 RX irq enable, bit27 TX-empty irq enable.
- a=5, read: RX FIFO count in [31:24].
- a=6, read: TX FIFO count in [31:24].
- a=7: reads 0; writes are ignored.

Baud generation:
- DIV = round(CLOCK_FREQ / (BAUD_RATE × OVERSAMPLE)).
- A counter emits a one-cycle os_tick every DIV clocks.
- TX bit time is OVERSAMPLE os_ticks.

TX:
- States: IDLE, START, DATA, PARITY, STOP.
- In IDLE with the FIFO non-empty, pop the head into the shifter and go to START.
- Each state lasts one bit time: START drives 0, DATA sends 8 bits LSB first, PARITY is present only if enabled, STOP drives 1.
- After STOP, return to IDLE. The next byte may start immediately, back-to-back.

RX:
- rx passes through a 2-flop synchroniser.
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE→START on a sampled 0.
- In START, recheck at OVERSAMPLE/2 ticks. If rx is high, the edge was a glitch: return to IDLE.
- Sample each later bit at its mid-point, every OVERSAMPLE ticks. The phase resyncs on every start edge.
- At the STOP mid-point the frame completes:
  - stop=0 sets frame_err and discards the byte.
  - A parity mismatch sets parity_err and discards the byte.
  - Otherwise, if the FIFO is full, set rx_overrun and discard the byte.
  - Otherwise push the byte and pulse rxnew.
- Go to IDLE right after the stop mid-point, so back-to-back frames are accepted.

irq = (ctrl[26] & rx_nonempty) | (ctrl[27] & tx_empty).

## Timing
- Reset values:
  - Outputs: tx=1, irq=0, rxnew=0, rxdata=0.
  - Internal: both FIFOs empty, all flags 0, control=0, both FSMs IDLE, baud counter 0.
- Reset mid-frame aborts immediately: tx returns high on the next cycle.
- FIFO push and pop are registered, so counts and flags update the cycle after the strobe. spo for a=0 shows the new head the cycle after a pop.
- Push and pop in the same cycle on the same FIFO both take effect:
  - RX pop plus an RX push when full: the push succeeds and there is no overrun.
  - TX shifter pop plus a bus push when full: the push succeeds.
- A status W1C write in the same cycle as a flag-setting event leaves the flag set.
- The first tx falling edge comes ≤ DIV×OVERSAMPLE+2 cycles after the push into an idle TX FIFO.
- rxnew asserts in the cycle after the stop-bit mid-sample.
- FIFO pointers wrap modulo depth. Full is count==DEPTH and needs a counter one bit wider than the pointers.

## Test plan
All scenarios use CLOCK_FREQ=6400, BAUD_RATE=100, OVERSAMPLE=16, giving DIV=4 and a bit time of 64 clk.
- Reset, then read a=2 and a=3 → tx=1; a=2 reads 0x01000000; a=3 reads 0x04000000.
- Push 0x55 and 0xA3, parity off → tx shows start, 10101010, stop, then start, 11000101, stop, with no idle gap. a=2 bit24 returns to 1 after 20 bit times.
- Loop tx to rx and set parity odd. Send 0x00, 0x01, 0xFF → rx FIFO holds 00, 01, FF with count 3 and parity_err=0. Each pop via a=1 advances the head.
- Drive RX_DEPTH+1 frames with no pops → count=RX_DEPTH, rx_full=1, rx_overrun=1. The FIFO contents are the first RX_DEPTH bytes.
- Drive a frame with stop=0, then a frame with wrong even parity → frame_err and parity_err set and no push. Writing 0x60000000 to a=3 clears both.
- Set control 0x04000000, receive one byte → irq rises the cycle after rxnew. irq falls the cycle after the a=1 pop.
